// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit CPU front end.
//   - instruction field positions (opcode / rd / rs1 / rs2)
//   - opcode encodings seen by the ALU
//   - register-file geometry
package cpu_pkg;

   localparam int NUM_REGS = 16;
   localparam int REG_AW   = 4;

   localparam int OPC_MSB = 15;
   localparam int OPC_LSB = 12;
   localparam int RD_MSB  = 11;
   localparam int RD_LSB  = 8;
   localparam int RS1_MSB = 7;
   localparam int RS1_LSB = 4;
   localparam int RS2_MSB = 3;
   localparam int RS2_LSB = 0;

   typedef logic [REG_AW-1:0] reg_addr_t;

   localparam logic [3:0] OPC_ADD  = 4'b0000;
   localparam logic [3:0] OPC_SUB  = 4'b0001;
   localparam logic [3:0] OPC_AND  = 4'b0010;
   localparam logic [3:0] OPC_OR   = 4'b0011;
   localparam logic [3:0] OPC_XOR  = 4'b0100;
   localparam logic [3:0] OPC_NOT  = 4'b0101;
   localparam logic [3:0] OPC_SHL  = 4'b0110;
   localparam logic [3:0] OPC_SHR  = 4'b0111;
   localparam logic [3:0] OPC_ROL  = 4'b1000;
   localparam logic [3:0] OPC_ROR  = 4'b1001;
   localparam logic [3:0] OPC_INC  = 4'b1010;
   localparam logic [3:0] OPC_DEC  = 4'b1011;
   localparam logic [3:0] OPC_MOV  = 4'b1100;
   localparam logic [3:0] OPC_CMP  = 4'b1101;
   localparam logic [3:0] OPC_SHL4 = 4'b1110;
   localparam logic [3:0] OPC_SHR4 = 4'b1111;

   function automatic bit is_zero_reg(input reg_addr_t addr);
      return addr == '0;
   endfunction

endpackage

// File: rtl/regfile_core.sv
// 16-entry register file: two combinational read ports, one synchronous
// write port. R0 always reads zero and ignores writes.
// Ports:
//   clk, rst_n         clock, synchronous active-low reset (clears R1..R15)
//   raddr_a/rdata_a    read port A
//   raddr_b/rdata_b    read port B
//   we/waddr/wdata     write port, takes effect on the rising edge
// Reads see the array contents before the edge, so a same-cycle write to
// the register being read is not forwarded.
module regfile_core
   import cpu_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  reg_addr_t        raddr_a,
   output logic [WIDTH-1:0] rdata_a,
   input  reg_addr_t        raddr_b,
   output logic [WIDTH-1:0] rdata_b,
   input  logic             we,
   input  reg_addr_t        waddr,
   input  logic [WIDTH-1:0] wdata
);

   logic [WIDTH-1:0] regs [NUM_REGS];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs[i] <= '0;
         end
      end else if (we && !is_zero_reg(waddr)) begin
         regs[waddr] <= wdata;
      end
   end

   // R0 is muxed to zero so it never depends on reset having been applied.
   assign rdata_a = is_zero_reg(raddr_a) ? '0 : regs[raddr_a];
   assign rdata_b = is_zero_reg(raddr_b) ? '0 : regs[raddr_b];

endmodule

// File: rtl/alu_operand_stage.sv
// Decode + register-file stage feeding the ALU.
// Splits instr into opcode/rd/rs1/rs2, drives op1/op2 from the register
// file combinationally, writes alu_result back to rd on the next edge,
// latches the ALU zero/overflow flags and counts retired instructions.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   instr, instr_valid    instruction word and its execute strobe
//   clr_flags             clear flag_z/flag_v when no instruction executes
//   opcode, op1, op2      to ALU (follow instr regardless of instr_valid)
//   alu_result/zero/ovf   from ALU
//   flag_z, flag_v        registered flags
//   retired               wrapping count of executed instructions
// Build option: STICKY_OVF_EN makes flag_v accumulate overflow until
// cleared by clr_flags or reset.
module alu_operand_stage
   import cpu_pkg::*;
#(
   parameter int WIDTH     = 16,
   parameter int CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [15:0]          instr,
   input  logic                 instr_valid,
   input  logic                 clr_flags,
   output logic [3:0]           opcode,
   output logic [WIDTH-1:0]     op1,
   output logic [WIDTH-1:0]     op2,
   input  logic [WIDTH-1:0]     alu_result,
   input  logic                 alu_zero,
   input  logic                 alu_ovf,
   output logic                 flag_z,
   output logic                 flag_v,
   output logic [CNT_WIDTH-1:0] retired
);

   reg_addr_t rd, rs1, rs2;

   assign opcode = instr[OPC_MSB:OPC_LSB];
   assign rd     = instr[RD_MSB:RD_LSB];
   assign rs1    = instr[RS1_MSB:RS1_LSB];
   assign rs2    = instr[RS2_MSB:RS2_LSB];

   regfile_core #(.WIDTH(WIDTH)) u_regfile (
      .clk     (clk),
      .rst_n   (rst_n),
      .raddr_a (rs1),
      .rdata_a (op1),
      .raddr_b (rs2),
      .rdata_b (op2),
      .we      (instr_valid),
      .waddr   (rd),
      .wdata   (alu_result)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         flag_z  <= 1'b0;
         flag_v  <= 1'b0;
         retired <= '0;
      end else if (instr_valid) begin
         flag_z  <= alu_zero;
`ifdef STICKY_OVF_EN
         // A same-edge clear drops the accumulated history; this
         // instruction's overflow still registers.
         flag_v  <= clr_flags ? alu_ovf : (flag_v | alu_ovf);
`else
         flag_v  <= alu_ovf;
`endif
         retired <= retired + 1'b1;
      end else if (clr_flags) begin
         flag_z  <= 1'b0;
         flag_v  <= 1'b0;
      end
   end

endmodule
